// File: rtl/conv_window_feeder.sv
// conv_window_feeder: raster pixel stream to 3x3 signed windows for the PE array.
// Two line buffers supply the upper two window rows; a 3x3 shift window tracks the
// most recent three columns; one registered output stage with a valid/ready handshake.
module conv_window_feeder #(
  parameter int XW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic signed [XW-1:0] i_x,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [9*XW-1:0]      o_win,
  output logic                 o_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic signed [XW-1:0] win_q [9];
  logic signed [XW-1:0] win_d [9];
  logic                 o_valid_q, o_valid_d;
  logic                 o_last_q, o_last_d;
  logic [9*XW-1:0]      o_win_q, o_win_d;

  // Line buffers hold pixels of row-1 (lb1) and row-2 (lb2), indexed by column.
  logic signed [XW-1:0] lb1_mem [IMG_W];
  logic signed [XW-1:0] lb2_mem [IMG_W];

  logic accept;
  logic emit;

  // Ready depends only on the output register, never on i_valid.
  assign o_ready = i_ready || !o_valid_q;
  assign accept  = i_valid && o_ready;
  assign emit    = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_win   = o_win_q;

  // Next-state: window shift and raster counters on accept, output register load/clear.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_win_d   = o_win_q;

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb2_mem[col_q];
      win_d[5] = lb1_mem[col_q];
      win_d[8] = i_x;

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (emit) begin
      o_valid_d = 1'b1;
      o_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      for (int k = 0; k < 9; k++) begin
        o_win_d[XW*k +: XW] = win_d[k];
      end
    end else if (i_ready) begin
      // Window consumed (or nothing pending) and no new one completes.
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end
  end

  // Control, window and output registers; asynchronous reset discards any pending window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_win_q   <= '0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_win_q   <= o_win_d;
      win_q     <= win_d;
    end
  end

  // Line buffer update on accept: the row-1 entry ages into row-2, the new pixel into row-1.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb2_mem[col_q] <= lb1_mem[col_q];
      lb1_mem[col_q] <= i_x;
    end
  end

endmodule
